// File: rtl/debug_trigger_pkg.sv
// Shared types for the LSA debug trigger: mode field layout, trigger sources, FSM states.
package debug_trigger_pkg;

  localparam int unsigned LSA_DATA_W = 96;
  localparam int unsigned MODE_W     = 8;
  localparam int unsigned BANK_W     = 2;
  localparam int unsigned OCC_W      = 4;
  localparam int unsigned HOLD_W     = 16;

  typedef enum logic [1:0] {
    SRC_OFF   = 2'd0,
    SRC_LEVEL = 2'd1,
    SRC_EDGE  = 2'd2,
    SRC_EXT   = 2'd3
  } trig_src_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_ARMED = 2'd2,
    ST_FIRED = 2'd3
  } trig_state_e;

  // lsa_mode as returned by the capture block: [7:4] occurrence N, [3:2] source, [1:0] bank
  typedef struct packed {
    logic [OCC_W-1:0]  occ;
    trig_src_e         src;
    logic [BANK_W-1:0] bank;
  } lsa_mode_t;

endpackage

// File: rtl/debug_sync_edge.sv
// STAGES-deep synchronizer followed by a rising-edge detector; STAGES = 0 bypasses the sync.
module debug_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic din_i,
  output logic rise_c_o
);

  logic sync_out;
  logic prev_q;

  if (STAGES == 0) begin : g_bypass
    assign sync_out = din_i;
  end else begin : g_sync
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sync_q <= '0;
      end else begin
        sync_q <= STAGES'({sync_q, din_i});
      end
    end

    assign sync_out = sync_q[STAGES-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sync_out;
    end
  end

  assign rise_c_o = sync_out & ~prev_q;

endmodule

// File: rtl/debug_trigger.sv
// Probe bank select, 2-stage data pipeline and occurrence-counted trigger FSM for the LSA.
module debug_trigger
  import debug_trigger_pkg::*;
#(
  parameter int unsigned EXT_SYNC = 2,
  parameter int unsigned HOLDOFF  = 0
) (
  input  logic                  lsa_clk,
  input  logic                  lsa_rst_n,
  input  logic [MODE_W-1:0]     lsa_mode,
  input  logic [LSA_DATA_W-1:0] probe0,
  input  logic [LSA_DATA_W-1:0] probe1,
  input  logic [LSA_DATA_W-1:0] probe2,
  input  logic [LSA_DATA_W-1:0] probe3,
  input  logic [LSA_DATA_W-1:0] trig_mask,
  input  logic [LSA_DATA_W-1:0] trig_value,
  input  logic                  ext_trigger,
  output logic [LSA_DATA_W-1:0] lsa_data,
  output logic                  lsa_trigger,
  output logic [1:0]            trig_state
);

  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLDOFF);

  lsa_mode_t             mode_c;
  logic [LSA_DATA_W-1:0] bank_sel_c;
  logic [LSA_DATA_W-1:0] s1_q;
  logic [LSA_DATA_W-1:0] data_q;
  logic [MODE_W-1:0]     mode_q;
  logic                  prev_match_q;
  logic                  match_c;
  logic                  rearm_c;
  logic                  ext_rise_c;
  logic                  event_c;

  trig_state_e           state_q, state_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic                  trig_q, trig_d;

  assign mode_c = lsa_mode_t'(lsa_mode);

  always_comb begin
    case (mode_c.bank)
      2'd0:    bank_sel_c = probe0;
      2'd1:    bank_sel_c = probe1;
      2'd2:    bank_sel_c = probe2;
      default: bank_sel_c = probe3;
    endcase
  end

  // Data pipeline plus the per-cycle history used for edge and re-arm detection
  always_ff @(posedge lsa_clk or negedge lsa_rst_n) begin
    if (!lsa_rst_n) begin
      s1_q         <= '0;
      data_q       <= '0;
      mode_q       <= '0;
      prev_match_q <= 1'b0;
    end else begin
      s1_q         <= bank_sel_c;
      data_q       <= s1_q;
      mode_q       <= lsa_mode;
      prev_match_q <= match_c;
    end
  end

  assign match_c = ((s1_q ^ trig_value) & trig_mask) == '0;
  assign rearm_c = lsa_mode != mode_q;

  debug_sync_edge #(
    .STAGES(EXT_SYNC)
  ) u_ext_sync (
    .clk_i   (lsa_clk),
    .rst_ni  (lsa_rst_n),
    .din_i   (ext_trigger),
    .rise_c_o(ext_rise_c)
  );

  always_comb begin
    case (mode_c.src)
      SRC_LEVEL: event_c = match_c;
      SRC_EDGE:  event_c = match_c & ~prev_match_q;
      SRC_EXT:   event_c = ext_rise_c;
      default:   event_c = 1'b0;
    endcase
  end

  always_ff @(posedge lsa_clk or negedge lsa_rst_n) begin
    if (!lsa_rst_n) begin
      state_q <= ST_IDLE;
      occ_q   <= '0;
      hold_q  <= '0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      hold_q  <= hold_d;
      trig_q  <= trig_d;
    end
  end

  // Re-arm (any mode change) wins over every state and discards a same-cycle event
  always_comb begin
    state_d = state_q;
    occ_d   = occ_q;
    hold_d  = hold_q;
    trig_d  = trig_q;
    if (rearm_c) begin
      state_d = ST_IDLE;
      trig_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          occ_d   = '0;
          hold_d  = HOLD_INIT;
          trig_d  = 1'b0;
          state_d = (HOLD_INIT != '0) ? ST_HOLD : ST_ARMED;
        end
        ST_HOLD: begin
          hold_d = hold_q - HOLD_W'(1);
          if (hold_q <= HOLD_W'(1)) begin
            state_d = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (event_c) begin
            if (occ_q == mode_c.occ) begin
              state_d = ST_FIRED;
              trig_d  = 1'b1;
            end else begin
              occ_d = occ_q + OCC_W'(1);
            end
          end
        end
        ST_FIRED: begin
          trig_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          trig_d  = 1'b0;
        end
      endcase
    end
  end

  assign lsa_data    = data_q;
  assign lsa_trigger = trig_q;
  assign trig_state  = state_q;

endmodule

// File: tb/tb_debug_trigger.sv
// Self-checking bench for debug_trigger: two instances (HOLDOFF 0 and 4) against a timeline model.
module tb_debug_trigger;

  localparam int EXT_S  = 2;
  localparam int HOLD_A = 0;
  localparam int HOLD_B = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  mode = 8'h00;
  logic [95:0] p0 = '0, p1 = '0, p2 = '0, p3 = '0;
  logic [95:0] mask = '0, val = '0;
  logic        ext = 1'b0;

  logic [95:0] data_a, data_b;
  logic        trig_a, trig_b;
  logic [1:0]  st_a, st_b;

  always #5 clk = ~clk;

  debug_trigger #(.EXT_SYNC(EXT_S), .HOLDOFF(HOLD_A)) dut_a (
    .lsa_clk(clk), .lsa_rst_n(rst_n), .lsa_mode(mode),
    .probe0(p0), .probe1(p1), .probe2(p2), .probe3(p3),
    .trig_mask(mask), .trig_value(val), .ext_trigger(ext),
    .lsa_data(data_a), .lsa_trigger(trig_a), .trig_state(st_a)
  );

  debug_trigger #(.EXT_SYNC(EXT_S), .HOLDOFF(HOLD_B)) dut_b (
    .lsa_clk(clk), .lsa_rst_n(rst_n), .lsa_mode(mode),
    .probe0(p0), .probe1(p1), .probe2(p2), .probe3(p3),
    .trig_mask(mask), .trig_value(val), .ext_trigger(ext),
    .lsa_data(data_b), .lsa_trigger(trig_b), .trig_state(st_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Timeline model: cycles elapsed since the FSM last sat in IDLE, plus events counted since arming
  int          cyc;
  logic [95:0] s1h;
  logic        pm;
  logic [7:0]  xh;
  logic [7:0]  mprev;
  int          idle_at [2];
  int          evc     [2];
  bit          fired   [2];

  typedef struct {
    logic [7:0] mode;
    logic [7:0] p1;
    logic       trig;
    logic [1:0] st;
    logic [7:0] d;
  } vec_t;
  vec_t vt [7];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int hold_of(input int m);
    return (m == 0) ? HOLD_A : HOLD_B;
  endfunction

  function automatic int state_at(input int m, input int c);
    int d;
    if (fired[m]) return 3;
    d = c - idle_at[m];
    if (d == 0) return 0;
    if (d <= hold_of(m)) return 1;
    return 2;
  endfunction

  task automatic model_reset();
    cyc = 0; s1h = '0; pm = 1'b0; xh = '0; mprev = '0;
    for (int m = 0; m < 2; m++) begin
      idle_at[m] = 0; evc[m] = 0; fired[m] = 1'b0;
    end
  endtask

  task automatic step();
    logic [95:0] sel, exp_data;
    logic        match, ev, rearm;
    logic [8:0]  v;
    int          st;
    case (mode[1:0])
      2'd0: sel = p0;
      2'd1: sel = p1;
      2'd2: sel = p2;
      default: sel = p3;
    endcase
    match = (((s1h ^ val) & mask) == '0);
    v = {xh, ext};
    case (mode[3:2])
      2'd1: ev = match;
      2'd2: ev = match & ~pm;
      2'd3: ev = v[EXT_S] & ~v[EXT_S+1];
      default: ev = 1'b0;
    endcase
    rearm = (mode != mprev);
    for (int m = 0; m < 2; m++) begin
      st = state_at(m, cyc);
      if (rearm) begin
        idle_at[m] = cyc + 1; evc[m] = 0; fired[m] = 1'b0;
      end else if (st == 2 && ev) begin
        evc[m]++;
        if (evc[m] == int'(mode[7:4]) + 1) fired[m] = 1'b1;
      end
    end
    exp_data = s1h;
    @(posedge clk); #1;
    cyc++;
    check("data_a", data_a, exp_data);
    check("data_b", data_b, exp_data);
    check("trig_a", 96'(trig_a), 96'(state_at(0, cyc) == 3));
    check("trig_b", 96'(trig_b), 96'(state_at(1, cyc) == 3));
    check("state_a", 96'(st_a), 96'(state_at(0, cyc)));
    check("state_b", 96'(st_b), 96'(state_at(1, cyc)));
    s1h = sel; pm = match; xh = v[7:0]; mprev = mode;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("rst_data_a", data_a, '0);
    check("rst_data_b", data_b, '0);
    check("rst_trig_a", 96'(trig_a), '0);
    check("rst_trig_b", 96'(trig_b), '0);
    check("rst_state_a", 96'(st_a), '0);
    check("rst_state_b", 96'(st_b), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();

    // Mode 0: data follows probe0, FSM arms and never fires
    for (int i = 0; i < 8; i++) begin
      p0 = {$urandom(), $urandom(), $urandom()};
      step();
    end
    p0 = '0;
    steps(4);
    check("off_never_fires", 96'(trig_a), '0);

    // Level trigger on bank 1, N = 0, applied as a vector table
    mask = 96'hFF; val = 96'h5A;
    vt[0] = '{8'h05, 8'h00, 1'b0, 2'd0, 8'h00};
    vt[1] = '{8'h05, 8'h00, 1'b0, 2'd2, 8'h00};
    vt[2] = '{8'h05, 8'h5A, 1'b0, 2'd2, 8'h00};
    vt[3] = '{8'h05, 8'h00, 1'b1, 2'd3, 8'h5A};
    vt[4] = '{8'h05, 8'h00, 1'b1, 2'd3, 8'h00};
    vt[5] = '{8'h05, 8'h5A, 1'b1, 2'd3, 8'h00};
    vt[6] = '{8'h05, 8'h00, 1'b1, 2'd3, 8'h5A};
    for (int i = 0; i < 7; i++) begin
      mode = vt[i].mode;
      p1   = 96'(vt[i].p1);
      step();
      check($sformatf("vec%0d_trig", i), 96'(trig_a), 96'(vt[i].trig));
      check($sformatf("vec%0d_state", i), 96'(st_a), 96'(vt[i].st));
      check($sformatf("vec%0d_data", i), 96'(data_a[7:0]), 96'(vt[i].d));
    end

    // Edge trigger, N = 3: three pulses then a held match fires on the 4th edge
    mode = 8'h38; p0 = '0;
    steps(8);
    for (int i = 0; i < 3; i++) begin
      p0 = 96'h5A; step();
      p0 = '0;     steps(2);
    end
    check("edge_not_yet", 96'(trig_a), '0);
    p0 = 96'h5A;
    steps(6);
    check("edge_fired", 96'(trig_a), 96'd1);

    // External trigger: fire, ignore a second pulse, re-arm clears, third pulse re-fires
    mode = 8'h0C; p0 = '0;
    steps(8);
    ext = 1'b1; step();
    ext = 1'b0; steps(2);
    check("ext_latency", 96'(trig_a), 96'd1);
    steps(3);
    ext = 1'b1; step();
    ext = 1'b0; steps(5);
    mode = 8'h0D; step();
    check("rearm_clear", 96'(trig_a), '0);
    steps(8);
    ext = 1'b1; step();
    ext = 1'b0; steps(5);
    check("ext_refire", 96'(trig_a), 96'd1);

    // Holdoff: constant match, instance b shows IDLE, 4x HOLD, then fires
    mask = '0; mode = 8'h04;
    steps(10);
    check("holdoff_fired_b", 96'(trig_b), 96'd1);

    // Re-arm in the same cycle as a qualifying event discards it
    mask = 96'hFF; val = 96'h5A; p0 = '0;
    mode = 8'h00; steps(2);
    mode = 8'h04; steps(8);
    p0 = 96'h5A; step();
    mode = 8'h14; p0 = '0; step();
    steps(8);
    check("rearm_discard", 96'(trig_a), '0);
    p0 = 96'h5A; step();
    p0 = '0; steps(4);
    check("occ_first_event", 96'(trig_a), '0);
    p0 = 96'h5A; step();
    p0 = '0; steps(2);
    check("occ_second_event", 96'(trig_a), 96'd1);

    // Reset asserted while FIRED
    do_reset();
    steps(8);

    // Randomized traffic with a narrow mask so matches are frequent
    mask = 96'hF; val = 96'($urandom_range(0, 15));
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) mode = 8'($urandom());
      p0 = {$urandom(), $urandom(), $urandom() & 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))};
      p1 = {$urandom(), $urandom(), $urandom() & 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))};
      p2 = {$urandom(), $urandom(), $urandom() & 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))};
      p3 = {$urandom(), $urandom(), $urandom() & 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))};
      ext = ($urandom_range(0, 3) == 0);
      if (i == 200) do_reset();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
